// File: rtl/audio_adc_deser_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_pkg                                                            |
// | Shared types and constants for the I2S ADC deserialiser.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package audio_pkg;

  // Deserialiser FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Default channel word width (bits captured per channel, MSB first)
  localparam int DEFAULT_SAMPLE_W = 16;

  // I2S places the MSB one bit clock after the lrck edge
  localparam int I2S_DELAY_BITS = 1;

  // lrck level encoding: low = left, high = right
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/audio_adc_deser_edge_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_sync                                                            |
// | STAGES-deep synchroniser for an asynchronous pin plus a single-cycle |
// | rise detector on the synchronised level.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic state_clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the pin through the synchroniser and remember the last synchronised level
  always_ff @(posedge state_clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign level = r_sync[STAGES-1];
  assign rise  = r_sync[STAGES-1] & ~r_prev;

endmodule : edge_sync
`default_nettype wire

// File: rtl/audio_adc_deser.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_adc_deser                                                      |
// | Deserialises the codec I2S ADC stream (bclk/lrck/adcdat) into        |
// | parallel signed left/right words with a per-frame valid strobe.      |
// | Optional: AUDIO_ADC_MONO_MIX_EN adds mono_out = (left+right) >>> 1.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module audio_adc_deser
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = DEFAULT_SAMPLE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       state_clk,
  input  logic                       reset,
  input  logic                       bclk,
  input  logic                       lrck,
  input  logic                       adcdat,
  output logic signed [SAMPLE_W-1:0] left_out,
  output logic signed [SAMPLE_W-1:0] right_out,
`ifdef AUDIO_ADC_MONO_MIX_EN
  output logic signed [SAMPLE_W-1:0] mono_out,
`endif
  output logic                       sample_valid,
  output logic                       frame_err
);

  localparam int               CNT_W      = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SAMPLE_W - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [SAMPLE_W-1:0] r_shift;
  logic [SAMPLE_W-1:0] r_left_hold;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_chan;
  logic                r_lr_prev;

  logic                w_bclk_rise;
  logic                w_lrck_s;
  logic                w_dat_s;
  logic                w_bclk_level_unused;
  logic                w_lrck_rise_unused;
  logic                w_dat_rise_unused;

  logic                w_lr_edge;
  logic                w_shift_en;
  logic                w_word_done;
  logic [SAMPLE_W-1:0] w_shift_next;
  logic                w_commit_left;
  logic                w_commit_right;
  logic                w_short_word;

  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .state_clk (state_clk),
    .reset     (reset),
    .din       (bclk),
    .level     (w_bclk_level_unused),
    .rise      (w_bclk_rise)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .state_clk (state_clk),
    .reset     (reset),
    .din       (lrck),
    .level     (w_lrck_s),
    .rise      (w_lrck_rise_unused)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_adcdat (
    .state_clk (state_clk),
    .reset     (reset),
    .din       (adcdat),
    .level     (w_dat_s),
    .rise      (w_dat_rise_unused)
  );

  // An lrck edge is a change of lrck between consecutive bclk rises; that
  // rise is the one-bit I2S delay slot, so it never shifts data.
  assign w_lr_edge    = w_bclk_rise & (w_lrck_s ^ r_lr_prev);
  assign w_shift_en   = w_bclk_rise & ~w_lr_edge & (r_state == SHIFT);
  assign w_word_done  = w_shift_en & (r_cnt == C_CNT_LAST);
  assign w_shift_next = {r_shift[SAMPLE_W-2:0], w_dat_s};

  // FSM state register
  always_ff @(posedge state_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state: every lrck edge (re)starts a word, a full word parks in HOLD
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_lr_edge) w_next_state = SHIFT;
      SHIFT:   if (w_lr_edge) w_next_state = SHIFT;
               else if (w_word_done) w_next_state = HOLD;
      HOLD:    if (w_lr_edge) w_next_state = SHIFT;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: commit strobes per channel and short-word detection
  always_comb begin
    w_commit_left  = 1'b0;
    w_commit_right = 1'b0;
    w_short_word   = 1'b0;
    if (r_state == SHIFT) begin
      w_short_word   = w_lr_edge;
      w_commit_left  = w_word_done & (r_chan == CH_LEFT);
      w_commit_right = w_word_done & (r_chan == CH_RIGHT);
    end
  end

`ifdef AUDIO_ADC_MONO_MIX_EN
  // One extra bit of headroom so the average never overflows
  logic [SAMPLE_W:0] w_mono_sum;
  assign w_mono_sum = {r_left_hold[SAMPLE_W-1], r_left_hold}
                    + {w_shift_next[SAMPLE_W-1], w_shift_next};
`endif

  // Shift/count datapath, left holding register and committed outputs
  always_ff @(posedge state_clk) begin
    if (reset) begin
      r_shift      <= '0;
      r_left_hold  <= '0;
      r_cnt        <= '0;
      r_chan       <= CH_LEFT;
      r_lr_prev    <= 1'b0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
`ifdef AUDIO_ADC_MONO_MIX_EN
      mono_out     <= '0;
`endif
    end else begin
      if (w_bclk_rise) r_lr_prev <= w_lrck_s;

      // A partial word is simply abandoned here; the new channel starts clean
      if (w_lr_edge) begin
        r_cnt  <= '0;
        r_chan <= w_lrck_s;
      end else if (w_shift_en) begin
        r_shift <= w_shift_next;
        r_cnt   <= r_cnt + CNT_W'(1);
      end

      if (w_commit_left) r_left_hold <= w_shift_next;

      if (w_commit_right) begin
        left_out  <= r_left_hold;
        right_out <= w_shift_next;
`ifdef AUDIO_ADC_MONO_MIX_EN
        mono_out  <= w_mono_sum[SAMPLE_W:1];
`endif
      end

      sample_valid <= w_commit_right;
      frame_err    <= w_short_word;
    end
  end

endmodule : audio_adc_deser
`default_nettype wire

// File: tb/tb_audio_adc_deser.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_audio_adc_deser                                                   |
// | Self-checking bench: I2S frames generated at state_clk = 8x bclk,    |
// | expected words queued on stimulus, compared against captured strobes.|
// | A "16-bit slot" here is the delay bit plus 16 data bits (17 bclks).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_audio_adc_deser;

  localparam int W         = 16;
  localparam int BCLK_HALF = 40;                 // bclk period 80 ns, state_clk 10 ns
  localparam int SLOT16    = 17;
  localparam int SLOT32    = 33;
  localparam int FRAME_CYC = 2 * SLOT16 * 8;     // state_clk cycles per 16-bit frame

  logic state_clk = 1'b0;
  logic reset, bclk, lrck, adcdat;
  logic signed [W-1:0] left_out, right_out;
  logic sample_valid, frame_err;
`ifdef AUDIO_ADC_MONO_MIX_EN
  logic signed [W-1:0] mono_out;
`endif

  audio_adc_deser #(.SAMPLE_W(W), .SYNC_STAGES(2)) dut (
    .state_clk    (state_clk),
    .reset        (reset),
    .bclk         (bclk),
    .lrck         (lrck),
    .adcdat       (adcdat),
    .left_out     (left_out),
    .right_out    (right_out),
`ifdef AUDIO_ADC_MONO_MIX_EN
    .mono_out     (mono_out),
`endif
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 state_clk = ~state_clk;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [W-1:0] m;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mdl_left_hold;
  int           total = 0;
  int           bad   = 0;

  // Captured strobes (written only by the monitor)
  logic [W-1:0] obs_l   [0:63];
  logic [W-1:0] obs_r   [0:63];
  logic [W-1:0] obs_m   [0:63];
  int           obs_cyc [0:63];
  int           obs_n    = 0;
  int           ferr_cnt = 0;
  int           cyc      = 0;
  int           rd       = 0;

  always @(posedge state_clk) cyc <= cyc + 1;

  always @(negedge state_clk) begin
    if (sample_valid === 1'b1 && obs_n < 64) begin
      obs_l[obs_n]   <= left_out;
      obs_r[obs_n]   <= right_out;
`ifdef AUDIO_ADC_MONO_MIX_EN
      obs_m[obs_n]   <= mono_out;
`else
      obs_m[obs_n]   <= '0;
`endif
      obs_cyc[obs_n] <= cyc;
      obs_n          <= obs_n + 1;
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] mono_of(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return W'(s >>> 1);
  endfunction

  task automatic drive_bit(input logic lr, input logic d);
    bclk = 1'b0; lrck = lr; adcdat = d;
    #BCLK_HALF;
    bclk = 1'b1;
    #BCLK_HALF;
  endtask

  // Delay bit, then ndata MSB-first bits of w, then junk 1s up to slot_len
  task automatic send_slot(input logic ch, input logic [W-1:0] w, input int ndata, input int slot_len);
    logic d;
    for (int i = 0; i < slot_len; i++) begin
      if (i == 0)          d = 1'b0;
      else if (i <= ndata) d = w[W-i];
      else                 d = 1'b1;
      drive_bit(ch, d);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int slot_len);
    exp_t e;
    mdl_left_hold = l;
    e.l = l; e.r = r; e.m = mono_of(l, r);
    exp_q.push_back(e);
    send_slot(1'b0, l, W, slot_len);
    send_slot(1'b1, r, W, slot_len);
  endtask

  task automatic settle();
    repeat (24) @(posedge state_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge state_clk);
    #1;
    total += 4;
    if (left_out !== 16'h0)     begin bad++; $display("FAIL rst_left: got %h want 0000", left_out); end
    if (right_out !== 16'h0)    begin bad++; $display("FAIL rst_right: got %h want 0000", right_out); end
    if (sample_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b want 0", sample_valid); end
    if (frame_err !== 1'b0)     begin bad++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
    mdl_left_hold = '0;
    reset = 1'b0;
    settle();
    rd = obs_n;
  endtask

  task automatic test_right_first();
    int f0;
    exp_t e;
    f0 = ferr_cnt;
    e.l = mdl_left_hold; e.r = 16'h0ABC; e.m = mono_of(e.l, e.r);
    exp_q.push_back(e);
    send_slot(1'b1, 16'h0ABC, W, SLOT16);
    settle();
    total += 2;
    if (obs_n - rd !== exp_q.size()) begin bad++; $display("FAIL rf_count: got %0d want %0d", obs_n - rd, exp_q.size()); end
    if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL rf_ferr: got %0d want 0", ferr_cnt - f0); end
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front();
      total += 2;
      if (obs_l[rd] !== e.l) begin bad++; $display("FAIL rf_left: got %h want %h", obs_l[rd], e.l); end
      if (obs_r[rd] !== e.r) begin bad++; $display("FAIL rf_right: got %h want %h", obs_r[rd], e.r); end
      rd++;
    end
    exp_q.delete(); rd = obs_n;
  endtask

  task automatic test_basic_and_long();
    int f0;
    exp_t e;
    f0 = ferr_cnt;
    send_frame(16'h1234, 16'hFEDC, SLOT16);
    send_frame(16'h8000, 16'h7FFF, SLOT32);
    settle();
    total += 2;
    if (obs_n - rd !== exp_q.size()) begin bad++; $display("FAIL bl_count: got %0d want %0d", obs_n - rd, exp_q.size()); end
    if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL bl_ferr: got %0d want 0", ferr_cnt - f0); end
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front();
      total += 2;
      if (obs_l[rd] !== e.l) begin bad++; $display("FAIL bl_left: got %h want %h", obs_l[rd], e.l); end
      if (obs_r[rd] !== e.r) begin bad++; $display("FAIL bl_right: got %h want %h", obs_r[rd], e.r); end
      rd++;
    end
    exp_q.delete(); rd = obs_n;
  endtask

  task automatic test_short_word();
    int f0;
    exp_t e;
    f0 = ferr_cnt;
    send_slot(1'b0, 16'hABCD, 9, 10);           // lrck toggles after 9 data bits
    e.l = mdl_left_hold; e.r = 16'h0001; e.m = mono_of(e.l, e.r);
    exp_q.push_back(e);
    send_slot(1'b1, 16'h0001, W, SLOT16);
    settle();
    total += 2;
    if (obs_n - rd !== exp_q.size()) begin bad++; $display("FAIL sw_count: got %0d want %0d", obs_n - rd, exp_q.size()); end
    if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL sw_ferr_cycles: got %0d want 1", ferr_cnt - f0); end
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front();
      total += 2;
      if (obs_l[rd] !== e.l) begin bad++; $display("FAIL sw_left: got %h want %h", obs_l[rd], e.l); end
      if (obs_r[rd] !== e.r) begin bad++; $display("FAIL sw_right: got %h want %h", obs_r[rd], e.r); end
      rd++;
    end
    exp_q.delete(); rd = obs_n;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   first;
    first = rd;
    send_frame(16'h0100, 16'h0200, SLOT16);
    send_frame(16'h0300, 16'h0400, SLOT16);
    send_frame(16'hFFFF, 16'h0001, SLOT16);
    settle();
    total++;
    if (obs_n - rd !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", obs_n - rd); end
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front();
      total += 2;
      if (obs_l[rd] !== e.l) begin bad++; $display("FAIL b2b_left: got %h want %h", obs_l[rd], e.l); end
      if (obs_r[rd] !== e.r) begin bad++; $display("FAIL b2b_right: got %h want %h", obs_r[rd], e.r); end
      if (rd > first) begin
        total++;
        if (obs_cyc[rd] - obs_cyc[rd-1] !== FRAME_CYC) begin
          bad++; $display("FAIL b2b_spacing: got %0d want %0d", obs_cyc[rd] - obs_cyc[rd-1], FRAME_CYC);
        end
      end
      rd++;
    end
    exp_q.delete(); rd = obs_n;
  endtask

  task automatic test_reset_mid_word();
    exp_t e;
    send_frame(16'h1111, 16'h2222, SLOT16);
    send_slot(1'b0, 16'h3333, W, SLOT16);
    send_slot(1'b1, 16'h4444, 8, 9);            // right word cut after 8 data bits
    @(negedge state_clk);
    reset = 1'b1;
    @(posedge state_clk);
    #1;
    total += 5;
    if (left_out !== 16'h0)    begin bad++; $display("FAIL rm_left: got %h want 0000", left_out); end
    if (right_out !== 16'h0)   begin bad++; $display("FAIL rm_right: got %h want 0000", right_out); end
    if (sample_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", sample_valid); end
    if (frame_err !== 1'b0)    begin bad++; $display("FAIL rm_ferr: got %b want 0", frame_err); end
    if (obs_n - rd !== 1)      begin bad++; $display("FAIL rm_pre_count: got %0d want 1", obs_n - rd); end
    if (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front();
      total += 2;
      if (obs_l[rd] !== e.l) begin bad++; $display("FAIL rm_pre_left: got %h want %h", obs_l[rd], e.l); end
      if (obs_r[rd] !== e.r) begin bad++; $display("FAIL rm_pre_right: got %h want %h", obs_r[rd], e.r); end
    end
    exp_q.delete(); rd = obs_n;
    repeat (2) @(posedge state_clk);
    reset = 1'b0;
    mdl_left_hold = '0;
    // Remainder of the interrupted right slot must not produce a strobe
    for (int i = 9; i < SLOT16; i++) drive_bit(1'b1, 1'b1);
    send_frame(16'h5555, 16'h6666, SLOT16);
    settle();
    total++;
    if (obs_n - rd !== 1) begin bad++; $display("FAIL rm_post_count: got %0d want 1", obs_n - rd); end
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front();
      total += 2;
      if (obs_l[rd] !== e.l) begin bad++; $display("FAIL rm_post_left: got %h want %h", obs_l[rd], e.l); end
      if (obs_r[rd] !== e.r) begin bad++; $display("FAIL rm_post_right: got %h want %h", obs_r[rd], e.r); end
      rd++;
    end
    exp_q.delete(); rd = obs_n;
  endtask

`ifdef AUDIO_ADC_MONO_MIX_EN
  task automatic test_mono();
    exp_t e;
    send_frame(16'h7FFF, 16'h7FFF, SLOT16);
    send_frame(16'h8000, 16'h0000, SLOT16);
    settle();
    total++;
    if (obs_n - rd !== 2) begin bad++; $display("FAIL mono_count: got %0d want 2", obs_n - rd); end
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front();
      total++;
      if (obs_m[rd] !== e.m) begin bad++; $display("FAIL mono_value: got %h want %h", obs_m[rd], e.m); end
      rd++;
    end
    exp_q.delete(); rd = obs_n;
  endtask
`endif

  initial begin
    reset = 1'b1; bclk = 1'b0; lrck = 1'b0; adcdat = 1'b0;
    mdl_left_hold = '0;
    repeat (2) @(posedge state_clk);
    #2;
    test_reset();
    test_right_first();
    test_basic_and_long();
    test_short_word();
    test_back_to_back();
    test_reset_mid_word();
`ifdef AUDIO_ADC_MONO_MIX_EN
    test_mono();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_audio_adc_deser
`default_nettype wire
